arb_mux_nto1: RTL and testbench
===============================

ARB_MUX_NTO1 -- requirements
Module: arb_mux_nto1

Interface
REQ-001 Parameter N, default 16: data width per channel in bits.
REQ-002 Parameter M, default 4: channel count, legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(M): width of the selection index.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 in_data  input  M*N: channel i occupies bits [i*N+N-1 : i*N].
REQ-007 in_valid  input  M: bit i means channel i presents a word.
REQ-008 in_ready  output  M: bit i means channel i's word is accepted this cycle.
REQ-009 mode  input  1: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-010 out_data  output  N: registered selected word.
REQ-011 out_valid  output  1: out_data holds an undelivered word.
REQ-012 out_ready  input  1: downstream accepts out_data this cycle.
REQ-013 out_sel  output  SEL_W: index of the channel that supplied out_data.

Function
REQ-014 Transfer on an input occurs when in_valid[i] && in_ready[i]; on the output when out_valid && out_ready.
REQ-015 The accept condition is: !out_valid || out_ready.
REQ-016 in_ready is one-hot or zero; it is nonzero only when the accept condition holds and at least one in_valid bit is set.
REQ-017 in_ready is a combinational function of in_valid, mode, the RR pointer, out_valid and out_ready; it never depends on in_data.
REQ-018 The winning channel is decided as follows.
- Fixed priority: the lowest set index of in_valid wins.
- Round-robin: the first set in_valid index found by searching upward from ptr, wrapping M-1 -> 0, wins.
REQ-019 On an input transfer from channel k, the block registers in_data[k] into out_data and k into out_sel, and sets out_valid to 1; latency is 1 cycle.
REQ-020 On an output transfer with no simultaneous input transfer, out_valid clears; out_data and out_sel hold their values.
REQ-021 On simultaneous output and input transfers, out_valid stays 1 and the new word replaces the old one, giving full throughput of one word per cycle.
REQ-022 While out_valid && !out_ready, out_data, out_sel and out_valid hold stable and in_ready is all zero (backpressure).
REQ-023 The RR pointer ptr updates to (k+1) mod M only on an input transfer from k; for k = M-1, ptr wraps to 0.
REQ-024 In mode 1, ptr holds its value; switching mode takes effect on the next arbitration with no state flush.
REQ-025 A channel whose in_valid is deasserted before it is granted loses nothing; no request state is stored.
REQ-026 For M not a power of two, ptr never takes a value >= M.

Reset
REQ-027 While rst_n = 0, the following hold asynchronously:
- out_valid = 0
- out_data = 0
- out_sel = 0
- ptr = 0
- in_ready = 0
REQ-028 Assertion of reset mid-transfer discards the held word; no transfer completes in a cycle in which rst_n is low.
REQ-029 Release of rst_n is synchronous to clk; the first grant is possible in the first rising edge after release.

Structure
REQ-030 A shared package holds the mode encodings (MODE_RR = 0, MODE_FIXED = 1) and the SEL_W derivation function.
REQ-031 Arbitration is a sub-module, rr_arbiter, parameterised by M.
- Its inputs are req, ptr and mode.
- Its outputs are a one-hot grant and a binary index.
- It is purely combinational.
REQ-032 ptr and the output register reside in arb_mux_nto1; the data select uses grant-indexed slicing, not a mux tree.

Verification
REQ-033 Fixed priority: N = 16, M = 4, mode = 1, in_valid = 4'b1010, out_ready = 1 -> channel 1 is granted every cycle and out_sel = 1 after 1 cycle.
REQ-034 Round-robin fairness: mode = 0, in_valid = 4'b1111 held for 8 cycles, out_ready = 1 -> out_sel sequence is 0,1,2,3,0,1,2,3 with out_valid continuously 1.
REQ-035 Backpressure: a word 16'hA5A5 is held from channel 2 with out_ready = 0 for 3 cycles -> in_ready = 0 and out_data = 16'hA5A5 stable; when out_ready rises, the next grant goes to channel 3.
REQ-036 Wrap and non-power-of-two: M = 3, ptr = 2, in_valid = 3'b001 -> channel 0 is granted and ptr becomes 1; ptr never reaches 3.
REQ-037 Reset mid-operation: rst_n is pulled low while out_valid = 1 -> out_valid, out_data and out_sel are 0 immediately, without waiting for a clock edge; after release the first grant is made from ptr = 0.
REQ-038 Idle: in_valid = 0 with out_valid = 0 -> in_ready = 0, out_valid stays 0 and ptr is unchanged.

Source files
------------

// File: rtl/arb_mux_nto1_pkg.sv
// arb_mux_nto1_pkg: mode encodings and selection-width helper shared by the arbiter and mux
package arb_mux_nto1_pkg;
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int sel_w_f(input int m);
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin / fixed-priority arbiter with one-hot and binary grant
module rr_arbiter
  import arb_mux_nto1_pkg::*;
#(
  parameter int M     = 4,
  parameter int SEL_W = sel_w_f(M)
) (
  input  logic [M-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [M-1:0]     gnt,
  output logic [SEL_W-1:0] idx
);
  logic w_found;
  int   w_j;

  // Scan starts at ptr in round-robin mode and at 0 in fixed mode; first hit wins
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int i = 0; i < M; i++) begin
      w_j = (mode == MODE_FIXED) ? i : (int'(ptr) + i) % M;
      if (req[w_j] && !w_found) begin
        gnt[w_j] = 1'b1;
        idx      = SEL_W'(w_j);
        w_found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arb_mux_nto1.sv
// arb_mux_nto1: M-to-1 arbitrated mux with a one-word registered output stage
module arb_mux_nto1
  import arb_mux_nto1_pkg::*;
#(
  parameter int N     = 16,
  parameter int M     = 4,
  parameter int SEL_W = sel_w_f(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [M*N-1:0]   in_data,
  input  logic [M-1:0]     in_valid,
  output logic [M-1:0]     in_ready,
  input  logic             mode,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel
);
  logic [SEL_W-1:0] r_ptr;
  logic [N-1:0]     r_data;
  logic [SEL_W-1:0] r_sel;
  logic             r_valid;
  logic [M-1:0]     w_gnt;
  logic [SEL_W-1:0] w_idx;
  logic             w_accept;
  logic             w_xfer;

  rr_arbiter #(.M(M), .SEL_W(SEL_W)) u_arb (
    .req  (in_valid),
    .ptr  (r_ptr),
    .mode (mode),
    .gnt  (w_gnt),
    .idx  (w_idx)
  );

  assign w_accept = !r_valid || out_ready;
  // rst_n gating keeps in_ready low asynchronously while reset is held
  assign in_ready = (rst_n && w_accept) ? w_gnt : '0;
  assign w_xfer   = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= in_data[int'(w_idx)*N +: N];
      r_sel   <= w_idx;
      r_valid <= 1'b1;
      if (mode == MODE_RR)
        r_ptr <= (w_idx == SEL_W'(M-1)) ? '0 : w_idx + 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;
endmodule

// File: tb/tb_arb_mux_nto1.sv
// tb_arb_mux_nto1: directed checks of arb_mux_nto1 at M=4 and at non-power-of-two M=3
module tb_arb_mux_nto1;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode, out_valid, out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic        mode3, out_valid3, out_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  arb_mux_nto1 #(.N(16), .M(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  arb_mux_nto1 #(.N(8), .M(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_sel(out_sel3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
    in_valid   = 4'b1010;
    mode       = 1'b1;
    out_ready  = 1'b1;
    in_data3   = {8'h12, 8'h11, 8'h10};
    in_valid3  = 3'b000;
    mode3      = 1'b0;
    out_ready3 = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    check("rst_no_xfer", 32'(out_valid), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check("fix_in_ready", 32'(in_ready), 32'b0010);
    step();
    check("fix_sel1", 32'(out_sel), 32'd1);
    check("fix_data1", 32'(out_data), 32'h2222);
    check("fix_valid1", 32'(out_valid), 32'd1);
    check("fix_in_ready2", 32'(in_ready), 32'b0010);
    step();
    check("fix_sel2", 32'(out_sel), 32'd1);
    in_valid = 4'b0000;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    step();
    check("idle_valid1", 32'(out_valid), 32'd0);
    step();
    check("idle_valid2", 32'(out_valid), 32'd0);
    check("idle_sel_hold", 32'(out_sel), 32'd1);
    mode     = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_sel", 32'(out_sel), 32'(k % 4));
      check("rr_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 4'b0100;
    step();
    check("bp_sel", 32'(out_sel), 32'd2);
    check("bp_data", 32'(out_data), 32'hA5A5);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      check("bp_hold_data", 32'(out_data), 32'hA5A5);
      check("bp_hold_sel", 32'(out_sel), 32'd2);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b1000);
    step();
    check("bp_next_sel", 32'(out_sel), 32'd3);
    check("bp_next_data", 32'(out_data), 32'h4444);
    in_valid = 4'b0010;
    step();
    check("pre_rst_sel", 32'(out_sel), 32'd1);
    in_valid = 4'b1111;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_sel", 32'(out_sel), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    step();
    check("mid_rst_hold", 32'(out_valid), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_sel", 32'(out_sel), 32'd0);
    check("post_rst_data", 32'(out_data), 32'h1111);
    in_valid  = 4'b0000;
    in_valid3 = 3'b010;
    step();
    check("m3_sel_a", 32'(out_sel3), 32'd1);
    in_valid3 = 3'b001;
    #1;
    check("m3_wrap_ready", 32'(in_ready3), 32'b001);
    step();
    check("m3_wrap_sel", 32'(out_sel3), 32'd0);
    check("m3_wrap_data", 32'(out_data3), 32'h10);
    in_valid3 = 3'b111;
    step();
    check("m3_ptr1_sel", 32'(out_sel3), 32'd1);
    in_valid3 = 3'b100;
    step();
    check("m3_top_sel", 32'(out_sel3), 32'd2);
    in_valid3 = 3'b111;
    step();
    check("m3_ptr_wrap0", 32'(out_sel3), 32'd0);
    check("m3_data0", 32'(out_data3), 32'h10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
